// File: rtl/ct_f_spsram_wrap_init_if.sv
// ct_f_spsram_wrap_init_if
//   Access bus of the wrapped single-port SRAM with self-clear.
//   master: drives A, CEN, GWEN, WEN, D, INIT_REQ; samples Q, INIT_BUSY,
//           INIT_DONE, ACC_ERR.
//   slave : the memory wrapper side.
//   CEN, GWEN and WEN are active low.
interface ct_f_spsram_wrap_init_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 54
);
    logic [ADDR_WIDTH-1:0] A;
    logic                  CEN;
    logic                  GWEN;
    logic [DATA_WIDTH-1:0] WEN;
    logic [DATA_WIDTH-1:0] D;
    logic [DATA_WIDTH-1:0] Q;
    logic                  INIT_REQ;
    logic                  INIT_BUSY;
    logic                  INIT_DONE;
    logic                  ACC_ERR;

    modport master (
        output A, CEN, GWEN, WEN, D, INIT_REQ,
        input  Q, INIT_BUSY, INIT_DONE, ACC_ERR
    );

    modport slave (
        input  A, CEN, GWEN, WEN, D, INIT_REQ,
        output Q, INIT_BUSY, INIT_DONE, ACC_ERR
    );
endinterface

// File: rtl/ct_f_spsram_wrap_init.sv
// ct_f_spsram_wrap_init
//   Single-port SRAM built from NSLICE slices of WRAP_SIZE bits sharing one
//   address, with a hardware clear sweep (after reset and on INIT_REQ).
//   Ports:
//     i_clk  - clock, all state on the rising edge
//     i_rst  - asynchronous active-high reset
//     bus    - slave modport: A/CEN/GWEN/WEN/D/INIT_REQ in,
//              Q/INIT_BUSY/INIT_DONE/ACC_ERR out
//   Read data appears 1 cycle after the access (2 with OUT_REG=1). Writes are
//   read-first. While CEN is high the RAM keeps reading the last captured
//   address, so Q follows later writes to that location.
module ct_f_spsram_wrap_init #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 54,
    parameter int WRAP_SIZE   = 27,
    parameter int OUT_REG     = 0,
    parameter int INIT_ON_RST = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL = '0
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    ct_f_spsram_wrap_init_if.slave  bus
);
    localparam int NSLICE = (DATA_WIDTH + WRAP_SIZE - 1) / WRAP_SIZE;
    localparam int PW     = NSLICE * WRAP_SIZE;
    localparam int DEPTH  = 1 << ADDR_WIDTH;

    typedef enum logic {ST_IDLE = 1'b0, ST_INIT = 1'b1} state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_vld;
    logic                  r_done;
    logic                  r_acc_err;
    logic                  r_auto;

    logic                  w_busy;
    logic                  w_user;
    logic                  w_wr;
    logic [ADDR_WIDTH-1:0] w_raddr;
    logic [PW-1:0]         w_dpad;
    logic [PW-1:0]         w_ipad;
    logic [NSLICE-1:0][WRAP_SIZE-1:0] w_rd;
    logic [PW-1:0]         w_rd_flat;
    logic [DATA_WIDTH-1:0] w_qg;

    assign w_busy  = (r_state == ST_INIT);
    assign w_user  = ~bus.CEN & ~w_busy;
    assign w_wr    = w_user & ~bus.GWEN;
    // With CEN high the RAM stays pointed at the last captured address.
    assign w_raddr = w_user ? bus.A : r_addr;

    // Last slice is zero-padded up to PW bits.
    always_comb begin
        w_dpad = '0;
        w_dpad[DATA_WIDTH-1:0] = bus.D;
        w_ipad = '0;
        w_ipad[DATA_WIDTH-1:0] = INIT_VAL;
    end

    for (genvar g = 0; g < NSLICE; g++) begin : g_slice
        localparam int LO = g * WRAP_SIZE;
        // Enable bit is the slice's top bit, clipped to the real word width.
        localparam int HI = (LO + WRAP_SIZE - 1 < DATA_WIDTH - 1) ?
                            (LO + WRAP_SIZE - 1) : (DATA_WIDTH - 1);

        logic [WRAP_SIZE-1:0] r_mem [DEPTH];
        logic [WRAP_SIZE-1:0] r_rd;
        logic                 w_sen;

        assign w_sen = ~bus.WEN[HI];

        // Sweep owns the write port while busy; the read register holds so
        // Q is frozen for the whole sweep.
        always_ff @(posedge i_clk) begin
            if (w_busy)
                r_mem[r_cnt] <= w_ipad[LO +: WRAP_SIZE];
            else if (w_wr && w_sen)
                r_mem[bus.A] <= w_dpad[LO +: WRAP_SIZE];
            if (!w_busy)
                r_rd <= r_mem[w_raddr];
        end

        assign w_rd[g] = r_rd;
    end

    assign w_rd_flat = w_rd;
    // Q stays zero until the first user read has completed.
    assign w_qg = r_vld ? w_rd_flat[DATA_WIDTH-1:0] : '0;

    if (PW > DATA_WIDTH) begin : g_pad
        logic w_unused_pad;
        assign w_unused_pad = ^w_rd_flat[PW-1:DATA_WIDTH];
    end

    if (OUT_REG != 0) begin : g_oreg
        logic [DATA_WIDTH-1:0] r_q;
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst)
                r_q <= '0;
            else if (!w_busy)
                r_q <= w_qg;
        end
        assign bus.Q = r_q;
    end else begin : g_noreg
        assign bus.Q = w_qg;
    end

    // r_auto turns the first post-reset edge into a sweep start, so a reset
    // mid-sweep simply restarts from address 0 without a DONE pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_vld     <= 1'b0;
            r_done    <= 1'b0;
            r_acc_err <= 1'b0;
            r_auto    <= (INIT_ON_RST != 0);
        end else begin
            r_done    <= 1'b0;
            r_acc_err <= w_busy & ~bus.CEN;
            if (w_user)
                r_addr <= bus.A;
            if (w_user && bus.GWEN)
                r_vld <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    r_auto <= 1'b0;
                    if (r_auto || bus.INIT_REQ) begin
                        r_state <= ST_INIT;
                        r_cnt   <= '0;
                    end
                end
                ST_INIT: begin
                    if (&r_cnt) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + ADDR_WIDTH'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.INIT_BUSY = w_busy;
    assign bus.INIT_DONE = r_done;
    assign bus.ACC_ERR   = r_acc_err;
endmodule

// File: tb/tb_ct_f_spsram_wrap_init.sv
// Bench for ct_f_spsram_wrap_init: three instances (defaults, OUT_REG=1,
// DATA_WIDTH=40/WRAP_SIZE=16). The default instance is tracked by a
// behavioural memory model.
module tb_ct_f_spsram_wrap_init;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [53:0] ALL1 = {54{1'b1}};

    ct_f_spsram_wrap_init_if #(.ADDR_WIDTH(8), .DATA_WIDTH(54)) if0 ();
    ct_f_spsram_wrap_init_if #(.ADDR_WIDTH(8), .DATA_WIDTH(54)) if1 ();
    ct_f_spsram_wrap_init_if #(.ADDR_WIDTH(8), .DATA_WIDTH(40)) if2 ();

    ct_f_spsram_wrap_init u0 (.i_clk(clk), .i_rst(rst), .bus(if0));
    ct_f_spsram_wrap_init #(.OUT_REG(1)) u1 (.i_clk(clk), .i_rst(rst), .bus(if1));
    ct_f_spsram_wrap_init #(.DATA_WIDTH(40), .WRAP_SIZE(16)) u2 (.i_clk(clk), .i_rst(rst), .bus(if2));

    // Reference model for u0
    logic [53:0] mm [256];
    logic [7:0]  m_addr;
    bit          m_vld, m_auto;
    int          m_left;
    logic [53:0] e_q;
    bit          e_done, e_acc;

    task automatic m_reset();
        m_addr = 0; m_vld = 0; m_auto = 1; m_left = 0;
        e_q = 0; e_done = 0; e_acc = 0;
    endtask

    task automatic idle_all();
        if0.CEN = 1; if0.GWEN = 1; if0.WEN = '1; if0.D = '0; if0.A = '0; if0.INIT_REQ = 0;
        if1.CEN = 1; if1.GWEN = 1; if1.WEN = '1; if1.D = '0; if1.A = '0; if1.INIT_REQ = 0;
        if2.CEN = 1; if2.GWEN = 1; if2.WEN = '1; if2.D = '0; if2.A = '0; if2.INIT_REQ = 0;
    endtask

    task automatic reset_release();
        @(posedge clk); #1;
        rst = 0;
        m_reset();
    endtask

    // One clock on u0 plus the model step; returns 1 time unit after the edge.
    task automatic cyc0(input logic cen, input logic gwen, input logic [53:0] wen,
                        input logic [53:0] d, input logic [7:0] a, input logic ireq);
        logic [53:0] rd;
        if0.CEN = cen; if0.GWEN = gwen; if0.WEN = wen; if0.D = d; if0.A = a; if0.INIT_REQ = ireq;
        @(posedge clk);
        e_done = 0; e_acc = 0;
        if (m_left > 0) begin
            e_acc = !cen;
            m_left--;
            if (m_left == 0) e_done = 1;
        end else begin
            if (!cen) m_addr = a;
            rd = mm[m_addr];
            if (!cen && gwen) m_vld = 1;
            if (!cen && !gwen) begin
                if (!wen[26]) mm[a][26:0]  = d[26:0];
                if (!wen[53]) mm[a][53:27] = d[53:27];
            end
            e_q = m_vld ? rd : 54'h0;
            if (ireq || m_auto) begin
                m_left = 256;
                for (int i = 0; i < 256; i++) mm[i] = 54'h0;
            end
            m_auto = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1; #2;
        n_vec++; if (if0.Q !== 54'h0) begin n_err++; $display("FAIL rst_q0: got %h want 0", if0.Q); end
        n_vec++; if (if0.INIT_BUSY !== 1'b0) begin n_err++; $display("FAIL rst_busy0: got %b want 0", if0.INIT_BUSY); end
        n_vec++; if (if0.INIT_DONE !== 1'b0) begin n_err++; $display("FAIL rst_done0: got %b want 0", if0.INIT_DONE); end
        n_vec++; if (if0.ACC_ERR !== 1'b0) begin n_err++; $display("FAIL rst_acc0: got %b want 0", if0.ACC_ERR); end
        n_vec++; if ({if1.Q, if1.INIT_BUSY, if1.INIT_DONE, if1.ACC_ERR} !== 57'h0) begin
            n_err++; $display("FAIL rst_u1: q=%h busy=%b done=%b acc=%b want all 0", if1.Q, if1.INIT_BUSY, if1.INIT_DONE, if1.ACC_ERR); end
        n_vec++; if ({if2.Q, if2.INIT_BUSY, if2.INIT_DONE, if2.ACC_ERR} !== 43'h0) begin
            n_err++; $display("FAIL rst_u2: q=%h busy=%b done=%b acc=%b want all 0", if2.Q, if2.INIT_BUSY, if2.INIT_DONE, if2.ACC_ERR); end
        reset_release();
    endtask

    // Sweep after reset release, then every address reads back zero.
    task automatic test_init_sweep(input string tag);
        int nb = 0, nd = 0;
        for (int c = 0; c < 300; c++) begin
            cyc0(1, 1, ALL1, 54'h0, 8'h0, 0);
            if (if0.INIT_BUSY) nb++;
            if (if0.INIT_DONE) nd++;
            n_vec++;
            if ({if0.Q, if0.INIT_BUSY, if0.INIT_DONE, if0.ACC_ERR} !== {e_q, m_left > 0, e_done, e_acc}) begin
                n_err++;
                $display("FAIL %s_cyc%0d: q=%h busy=%b done=%b acc=%b want q=%h busy=%b done=%b acc=%b",
                         tag, c, if0.Q, if0.INIT_BUSY, if0.INIT_DONE, if0.ACC_ERR, e_q, m_left > 0, e_done, e_acc);
            end
        end
        n_vec++; if (nb != 256) begin n_err++; $display("FAIL %s_busy_len: got %0d want 256", tag, nb); end
        n_vec++; if (nd != 1) begin n_err++; $display("FAIL %s_done_cnt: got %0d want 1", tag, nd); end
    endtask

    task automatic test_read_all();
        for (int a = 0; a < 256; a++) begin
            cyc0(0, 1, ALL1, 54'h0, 8'(a), 0);
            n_vec++;
            if (if0.Q !== e_q || e_q !== 54'h0) begin
                n_err++; $display("FAIL read_all_%02h: got %h want 0", a, if0.Q);
            end
        end
    endtask

    task automatic test_wen_slices();
        logic [53:0] wen;
        cyc0(0, 0, 54'h0, ALL1, 8'h10, 0);
        wen = 54'h0; wen[26] = 1'b1;
        cyc0(0, 0, wen, 54'h0, 8'h10, 0);
        n_vec++; if (if0.Q !== e_q) begin n_err++; $display("FAIL read_first: got %h want %h", if0.Q, e_q); end
        cyc0(0, 1, ALL1, 54'h0, 8'h10, 0);
        n_vec++; if (if0.Q !== e_q) begin n_err++; $display("FAIL wen_slice: got %h want %h", if0.Q, e_q); end
        // Address holding: CEN high keeps showing 0x10.
        cyc0(1, 1, ALL1, 54'h0, 8'h33, 0);
        n_vec++; if (if0.Q !== e_q) begin n_err++; $display("FAIL hold_addr: got %h want %h", if0.Q, e_q); end
    endtask

    task automatic test_random();
        logic [63:0] r64, w64;
        logic cen, gwen, ireq;
        for (int c = 0; c < 700; c++) begin
            r64 = {$urandom(), $urandom()};
            w64 = {$urandom(), $urandom()};
            cen  = ($urandom_range(0, 3) == 0);
            gwen = $urandom_range(0, 1) == 1;
            ireq = ($urandom_range(0, 249) == 0);
            cyc0(cen, gwen, w64[53:0], r64[53:0], 8'($urandom_range(0, 15)), ireq);
            n_vec++;
            if ({if0.Q, if0.INIT_BUSY, if0.INIT_DONE, if0.ACC_ERR} !== {e_q, m_left > 0, e_done, e_acc}) begin
                n_err++;
                $display("FAIL rand_cyc%0d: q=%h busy=%b done=%b acc=%b want q=%h busy=%b done=%b acc=%b",
                         c, if0.Q, if0.INIT_BUSY, if0.INIT_DONE, if0.ACC_ERR, e_q, m_left > 0, e_done, e_acc);
            end
        end
        // Drain any sweep the random traffic started.
        for (int c = 0; c < 300 && m_left > 0; c++) cyc0(1, 1, ALL1, 54'h0, 8'h0, 0);
    endtask

    // INIT_REQ together with a write, then user traffic during the sweep.
    task automatic test_init_collide();
        logic [63:0] r64;
        int nd = 0;
        cyc0(0, 0, 54'h0, 54'h1234, 8'h05, 1);
        n_vec++; if (if0.INIT_BUSY !== 1'b1) begin n_err++; $display("FAIL collide_busy: got %b want 1", if0.INIT_BUSY); end
        for (int c = 0; c < 256; c++) begin
            r64 = {$urandom(), $urandom()};
            cyc0(logic'($urandom_range(0, 1)), 0, 54'h0, r64[53:0], 8'h05, logic'($urandom_range(0, 1)));
            if (if0.INIT_DONE) nd++;
            n_vec++;
            if ({if0.Q, if0.ACC_ERR, if0.INIT_BUSY} !== {e_q, e_acc, m_left > 0}) begin
                n_err++;
                $display("FAIL collide_cyc%0d: q=%h acc=%b busy=%b want q=%h acc=%b busy=%b",
                         c, if0.Q, if0.ACC_ERR, if0.INIT_BUSY, e_q, e_acc, m_left > 0);
            end
        end
        n_vec++; if (nd != 1) begin n_err++; $display("FAIL collide_done_cnt: got %0d want 1", nd); end
        cyc0(1, 1, ALL1, 54'h0, 8'h0, 0);
        n_vec++; if (if0.INIT_BUSY !== 1'b0) begin n_err++; $display("FAIL collide_no_requeue: busy=%b want 0", if0.INIT_BUSY); end
        cyc0(0, 1, ALL1, 54'h0, 8'h05, 0);
        n_vec++; if (if0.Q !== 54'h0) begin n_err++; $display("FAIL collide_read05: got %h want 0", if0.Q); end
    endtask

    task automatic test_rst_mid_sweep();
        cyc0(1, 1, ALL1, 54'h0, 8'h0, 1);
        for (int c = 0; c < 128; c++) cyc0(1, 1, ALL1, 54'h0, 8'h0, 0);
        rst = 1; #2;
        n_vec++; if (if0.INIT_BUSY !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy: got %b want 0", if0.INIT_BUSY); end
        n_vec++; if (if0.Q !== 54'h0) begin n_err++; $display("FAIL mid_rst_q: got %h want 0", if0.Q); end
        n_vec++; if ({if0.INIT_DONE, if0.ACC_ERR} !== 2'b00) begin
            n_err++; $display("FAIL mid_rst_flags: done=%b acc=%b want 0 0", if0.INIT_DONE, if0.ACC_ERR); end
        reset_release();
        test_init_sweep("mid_restart");
    endtask

    task automatic test_out_reg();
        logic [63:0] r1, r2;
        int k = 0;
        r1 = {$urandom(), $urandom()};
        r2 = {$urandom(), $urandom()};
        while (if1.INIT_BUSY && k < 600) begin @(posedge clk); #1; k++; end
        n_vec++; if (if1.INIT_BUSY !== 1'b0) begin n_err++; $display("FAIL oreg_wait: busy=%b want 0", if1.INIT_BUSY); end
        if1.CEN = 0; if1.GWEN = 0; if1.WEN = '0; if1.A = 8'h10; if1.D = r1[53:0];
        @(posedge clk); #1;
        n_vec++; if (if1.Q !== 54'h0) begin n_err++; $display("FAIL oreg_gate: got %h want 0", if1.Q); end
        if1.GWEN = 1;
        @(posedge clk); #1;
        if1.CEN = 1; if1.A = 8'h77;
        n_vec++; if (if1.Q !== 54'h0) begin n_err++; $display("FAIL oreg_n1: got %h want 0", if1.Q); end
        @(posedge clk); #1;
        n_vec++; if (if1.Q !== r1[53:0]) begin n_err++; $display("FAIL oreg_n2: got %h want %h", if1.Q, r1[53:0]); end
        if1.CEN = 0; if1.GWEN = 0; if1.A = 8'h10; if1.D = r2[53:0];
        @(posedge clk); #1;
        if1.CEN = 1; if1.GWEN = 1; if1.A = 8'h33;
        @(posedge clk); #1;
        n_vec++; if (if1.Q !== r1[53:0]) begin n_err++; $display("FAIL oreg_prewrite: got %h want %h", if1.Q, r1[53:0]); end
        @(posedge clk); #1;
        n_vec++; if (if1.Q !== r2[53:0]) begin n_err++; $display("FAIL oreg_rehold: got %h want %h", if1.Q, r2[53:0]); end
    endtask

    task automatic test_narrow();
        int k = 0;
        while (if2.INIT_BUSY && k < 600) begin @(posedge clk); #1; k++; end
        n_vec++; if (if2.INIT_BUSY !== 1'b0) begin n_err++; $display("FAIL narrow_wait: busy=%b want 0", if2.INIT_BUSY); end
        if2.CEN = 0; if2.GWEN = 0; if2.WEN = '0; if2.A = 8'h03; if2.D = 40'hFF_FFFF_FFFF;
        @(posedge clk); #1;
        if2.WEN = 40'h7F_FFFF_FFFF; if2.D = '0;
        @(posedge clk); #1;
        if2.GWEN = 1; if2.WEN = '1;
        @(posedge clk); #1;
        n_vec++; if (if2.Q !== 40'h00_FFFF_FFFF) begin n_err++; $display("FAIL narrow_top: got %h want 00ffffffff", if2.Q); end
        if2.GWEN = 0; if2.WEN = 40'hFF_FFFF_7FFF; if2.D = '0;
        @(posedge clk); #1;
        if2.GWEN = 1; if2.WEN = '1;
        @(posedge clk); #1;
        n_vec++; if (if2.Q !== 40'h00_FFFF_0000) begin n_err++; $display("FAIL narrow_low: got %h want 00ffff0000", if2.Q); end
        if2.CEN = 1;
    endtask

    initial begin
        idle_all();
        m_reset();
        #1;
        test_reset();
        test_init_sweep("por");
        test_read_all();
        test_wen_slices();
        test_random();
        test_init_collide();
        test_rst_mid_sweep();
        idle_all();
        test_out_reg();
        test_narrow();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
